// File: rtl/nvram_sd_sequencer.sv
// rtl/nvram_sd_sequencer.sv - sector-by-sector save-state transfer sequencer between state RAM and hps_io SD
// Optional handshake timeout abort enabled by defining NVSEQ_TIMEOUT_EN.
module nvram_sd_sequencer #(
  parameter int          SECT_BITS = 6,
  parameter int          SLOT_BITS = 2,
  parameter logic [23:0] TIMEOUT   = 24'hFFFFFF
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ena,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic [SLOT_BITS-1:0] slot,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  output logic                 busy,
  output logic                 loading,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t      state, state_n;
  logic        dir, dir_n;
  logic [31:0] lba_n;
  logic        rd_n, wr_n, busy_n, loading_n, done_n;
  logic        load_q, save_q, ack_q;
  logic        load_edge, save_edge, last_sect;

  // ena gates the level before edge detection, so ena rising under a held request counts as an edge
  assign load_edge = load_req & ena & ~load_q;
  assign save_edge = save_req & ena & ~save_q;
  assign last_sect = &sd_lba[SECT_BITS-1:0];

`ifdef NVSEQ_TIMEOUT_EN
  logic [23:0] tmo_cnt, tmo_cnt_n;
  logic        err_r, err_n;
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    dir_n     = dir;
    lba_n     = sd_lba;
    rd_n      = sd_rd;
    wr_n      = sd_wr;
    busy_n    = busy;
    loading_n = loading;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (load_edge || save_edge) begin
          state_n   = REQ;
          dir_n     = load_edge;
          lba_n     = 32'({slot, {SECT_BITS{1'b0}}});
          rd_n      = load_edge;
          wr_n      = ~load_edge;
          busy_n    = 1'b1;
          loading_n = load_edge;
        end
      end
      REQ: begin
        if (!ack_q && sd_ack) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          state_n = XFER;
        end
      end
      XFER: begin
        if (ack_q && !sd_ack) begin
          if (last_sect) begin
            state_n   = IDLE;
            busy_n    = 1'b0;
            loading_n = 1'b0;
            done_n    = 1'b1;
          end else begin
            // sector field wraps within the slot; the slot bits never carry
            lba_n   = {sd_lba[31:SECT_BITS], sd_lba[SECT_BITS-1:0] + SECT_BITS'(1)};
            rd_n    = dir;
            wr_n    = ~dir;
            state_n = REQ;
          end
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef NVSEQ_TIMEOUT_EN
    err_n     = 1'b0;
    tmo_cnt_n = '0;
    if (state != IDLE && !(ack_q ^ sd_ack))
      tmo_cnt_n = tmo_cnt + 24'd1;
    if (state != IDLE && tmo_cnt == TIMEOUT) begin
      state_n   = IDLE;
      rd_n      = 1'b0;
      wr_n      = 1'b0;
      busy_n    = 1'b0;
      loading_n = 1'b0;
      done_n    = 1'b0;
      err_n     = 1'b1;
      tmo_cnt_n = '0;
    end
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      dir     <= 1'b0;
      sd_lba  <= '0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
      busy    <= 1'b0;
      loading <= 1'b0;
      done    <= 1'b0;
      load_q  <= 1'b0;
      save_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state   <= state_n;
      dir     <= dir_n;
      sd_lba  <= lba_n;
      sd_rd   <= rd_n;
      sd_wr   <= wr_n;
      busy    <= busy_n;
      loading <= loading_n;
      done    <= done_n;
      load_q  <= load_req & ena;
      save_q  <= save_req & ena;
      ack_q   <= sd_ack;
    end
  end

`ifdef NVSEQ_TIMEOUT_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_r   <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_n;
      err_r   <= err_n;
    end
  end
`endif

endmodule

// File: tb/tb_nvram_sd_sequencer.sv
// tb/tb_nvram_sd_sequencer.sv - directed self-checking bench for nvram_sd_sequencer
module tb_nvram_sd_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ena = 1'b0;
  logic        load_req = 1'b0;
  logic        save_req = 1'b0;
  logic [1:0]  slot = 2'd0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic        busy, loading, done, err;

  int tests_run = 0;
  int tests_failed = 0;
  int err_seen = 0;

  always #5 clk_sys = ~clk_sys;

  nvram_sd_sequencer #(.SECT_BITS(6), .SLOT_BITS(2), .TIMEOUT(24'd100)) dut (
    .clk_sys(clk_sys), .reset(reset), .ena(ena), .load_req(load_req), .save_req(save_req),
    .slot(slot), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .busy(busy), .loading(loading), .done(done), .err(err)
  );

  always @(negedge clk_sys) if (!reset && err) err_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (sd_rd || sd_wr) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
  endtask

  // Acts as hps_io: acks each sector 5 cycles after the request, holds ack 3 cycles
  task automatic run_xfer(input bit is_load, input int base, input int nsect);
    bit ok;
    for (int i = 0; i < nsect; i++) begin
      wait_req(ok);
      check("req_seen", 32'(ok), 32'd1);
      if (!ok) return;
      check("sd_lba", sd_lba, 32'(base + i));
      check("sd_rd", 32'(sd_rd), 32'(is_load));
      check("sd_wr", 32'(sd_wr), 32'(!is_load));
      check("busy_mid", 32'(busy), 32'd1);
      check("loading_mid", 32'(loading), 32'(is_load));
      cycles(5);
      sd_ack = 1'b1;
      cycles(3);
      check("rdwr_cleared", 32'(sd_rd | sd_wr), 32'd0);
      sd_ack = 1'b0;
      cycles(1);
      check("done", 32'(done), 32'(i == 63));
      if (i == 63) begin
        cycles(1);
        check("done_width", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("loading_after", 32'(loading), 32'd0);
        check("rdwr_after", 32'(sd_rd | sd_wr), 32'd0);
      end
    end
  endtask

  initial begin
    int k;
    // reset state
    cycles(3);
    reset = 1'b0;
    cycles(1);
    check("rst_lba", sd_lba, 32'd0);
    check("rst_rdwr", {30'd0, sd_rd, sd_wr}, 32'd0);
    check("rst_flags", {28'd0, busy, loading, done, err}, 32'd0);

    // 1: save into slot 2
    ena = 1'b1; slot = 2'd2;
    cycles(1);
    save_req = 1'b1;
    cycles(1);
    check("t1_latency_wr", 32'(sd_wr), 32'd1);
    check("t1_lba0", sd_lba, 32'h80);
    run_xfer(1'b0, 32'h80, 64);
    save_req = 1'b0;

    // 2: load from slot 0, loading high from the next cycle
    slot = 2'd0;
    cycles(2);
    load_req = 1'b1;
    cycles(1);
    check("t2_loading", 32'(loading), 32'd1);
    run_xfer(1'b1, 0, 64);
    load_req = 1'b0;

    // 3: simultaneous edges -> load; later edges while busy are dropped
    slot = 2'd1;
    cycles(2);
    load_req = 1'b1; save_req = 1'b1;
    cycles(1);
    check("t3_dir_rd", 32'(sd_rd), 32'd1);
    check("t3_dir_wr", 32'(sd_wr), 32'd0);
    save_req = 1'b0;
    cycles(1);
    save_req = 1'b1;
    run_xfer(1'b1, 64, 64);
    cycles(3);
    check("t3_no_replay", 32'(busy | sd_rd | sd_wr), 32'd0);
    load_req = 1'b0; save_req = 1'b0;

    // 4: ena gating
    ena = 1'b0; slot = 2'd3;
    cycles(2);
    load_req = 1'b1;
    cycles(3);
    check("t4_ignored", {29'd0, busy, sd_rd, sd_wr}, 32'd0);
    ena = 1'b1;
    cycles(1);
    check("t4_ena_edge_rd", 32'(sd_rd), 32'd1);
    check("t4_ena_edge_lba", sd_lba, 32'd192);
    run_xfer(1'b1, 192, 64);
    load_req = 1'b0;

    // 5: reset at sector 17 of a save, then restart from sector 0
    slot = 2'd3;
    cycles(2);
    save_req = 1'b1;
    run_xfer(1'b0, 192, 17);
    wait_req(k[0]);
    check("t5_sect17", sd_lba, 32'd209);
    reset = 1'b1; save_req = 1'b0;
    cycles(1);
    check("t5_rst_lba", sd_lba, 32'd0);
    check("t5_rst_out", {27'd0, sd_rd, sd_wr, busy, loading, done}, 32'd0);
    reset = 1'b0;
    cycles(2);
    save_req = 1'b1;
    cycles(1);
    check("t5_restart_lba", sd_lba, 32'd192);
    run_xfer(1'b0, 192, 64);
    save_req = 1'b0;
    cycles(2);

`ifdef NVSEQ_TIMEOUT_EN
    // 6: no ack -> abort 101 cycles after sd_wr rises
    slot = 2'd0;
    save_req = 1'b1;
    cycles(1);
    check("t6_wr_up", 32'(sd_wr), 32'd1);
    k = 0;
    for (int c = 1; c <= 200; c++) begin
      cycles(1);
      if (err) begin
        k = c;
        break;
      end
    end
    check("t6_err_delay", 32'(k), 32'd101);
    check("t6_abort_state", {29'd0, busy, sd_wr, done}, 32'd0);
    cycles(1);
    check("t6_err_width", 32'(err), 32'd0);
    save_req = 1'b0;
    check("t6_err_count", 32'(err_seen), 32'd1);
`else
    check("err_never", 32'(err_seen), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
